// File: rtl/ex_stage_if.sv
// ID/EX, forwarding and EX/MEM-facing signal bundle for the execute stage.
interface ex_stage_if;
  logic [87:0] idex_q;
  logic        ex_stall;
  logic        exmem_regwrite;
  logic [3:0]  exmem_dst;
  logic [15:0] exmem_result;
  logic        memwb_regwrite;
  logic [3:0]  memwb_dst;
  logic [15:0] memwb_data;
  logic [15:0] alu_result;
  logic [15:0] store_data;
  logic [2:0]  flags;
  logic [2:0]  flags_next;
  logic        halted;
  logic [3:0]  exmem_ctrl;
  logic [3:0]  exmem_dst_out;

  modport slave (
    input  idex_q, ex_stall, exmem_regwrite, exmem_dst, exmem_result,
           memwb_regwrite, memwb_dst, memwb_data,
    output alu_result, store_data, flags, flags_next, halted, exmem_ctrl, exmem_dst_out
  );

  modport master (
    output idex_q, ex_stall, exmem_regwrite, exmem_dst, exmem_result,
           memwb_regwrite, memwb_dst, memwb_data,
    input  alu_result, store_data, flags, flags_next, halted, exmem_ctrl, exmem_dst_out
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 16-bit ALU, {Z,V,N} flag register and sticky halt.
module ex_stage (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_PCS0 = 4'hC, OP_PCS1 = 4'hD, OP_PCS2 = 4'hE, OP_PCS3 = 4'hF
  } op_e;

  logic [6:0]  ctrl;
  logic [15:0] instr, imm, rs2_data, rs1_data;
  logic [3:0]  dst_id, rs1_id, rs2_id;
  logic        valid, halt_req, alu_src, update;
  op_e         op;

  assign ctrl     = bus.idex_q[6:0];
  assign instr    = bus.idex_q[22:7];
  assign imm      = bus.idex_q[38:23];
  assign rs2_data = bus.idex_q[54:39];
  assign rs1_data = bus.idex_q[70:55];
  assign dst_id   = bus.idex_q[74:71];
  assign rs1_id   = bus.idex_q[78:75];
  assign rs2_id   = bus.idex_q[82:79];
  assign alu_src  = ctrl[4];
  assign valid    = ctrl[5];
  assign halt_req = ctrl[6];
  assign op       = op_e'(instr[15:12]);
  assign update   = valid & ~bus.ex_stall;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.idex_q[87:83], instr[11:0]};

  logic [15:0] a, fwd_b, b;
  always_comb begin
    if (bus.exmem_regwrite && bus.exmem_dst == rs1_id)      a = bus.exmem_result;
    else if (bus.memwb_regwrite && bus.memwb_dst == rs1_id) a = bus.memwb_data;
    else                                                    a = rs1_data;
    if (bus.exmem_regwrite && bus.exmem_dst == rs2_id)      fwd_b = bus.exmem_result;
    else if (bus.memwb_regwrite && bus.memwb_dst == rs2_id) fwd_b = bus.memwb_data;
    else                                                    fwd_b = rs2_data;
  end
  assign b = alu_src ? imm : fwd_b;

  logic [15:0] sum, diff, result;
  logic        add_ovf, sub_ovf, sat;
  logic [8:0]  red_lo, red_hi;
  logic [9:0]  red_sum;
  logic [31:0] rot;
  logic [4:0]  nib_sum;
  logic [15:0] padd;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[15] == b[15]) && (sum[15] != a[15]);
  assign sub_ovf = (a[15] != b[15]) && (diff[15] != a[15]);
  assign red_lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]};
  assign red_hi  = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign red_sum = {1'b0, red_lo} + {1'b0, red_hi};
  assign rot     = {a, a} >> imm[3:0];

  // Nibble adds always use the forwarded rs2 value, never the immediate.
  always_comb begin
    padd    = '0;
    nib_sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      nib_sum = {fwd_b[4*i+3], fwd_b[4*i +: 4]} + {a[4*i+3], a[4*i +: 4]};
      if (nib_sum[4] != nib_sum[3]) padd[4*i +: 4] = nib_sum[4] ? 4'h8 : 4'h7;
      else                          padd[4*i +: 4] = nib_sum[3:0];
    end
  end

  always_comb begin
    result = '0;
    sat    = 1'b0;
    case (op)
      OP_ADD: begin
        sat    = add_ovf;
        result = add_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : sum;
      end
      OP_SUB: begin
        sat    = sub_ovf;
        result = sub_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : diff;
      end
      OP_XOR:        result = a ^ b;
      OP_RED:        result = {{6{red_sum[9]}}, red_sum};
      OP_SLL:        result = a << imm[3:0];
      OP_SRA:        result = $signed(a) >>> imm[3:0];
      OP_ROR:        result = rot[15:0];
      OP_PADDSB:     result = padd;
      OP_LW, OP_SW:  result = a + imm;
      OP_LLB:        result = (a & 16'hFF00) | {8'h00, imm[7:0]};
      OP_LHB:        result = (a & 16'h00FF) | {imm[7:0], 8'h00};
      default:       result = imm;
    endcase
  end

  logic [2:0] flags_q, flags_fn;
  logic       halted_q;
  logic       z_new;
  assign z_new = (result == 16'h0000);

  always_comb begin
    flags_fn = flags_q;
    case (op)
      OP_ADD, OP_SUB:                 flags_fn = {z_new, sat, result[15]};
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_fn = {z_new, flags_q[1:0]};
      default:                        flags_fn = flags_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else if (update) begin
      flags_q <= flags_fn;
      if (halt_req) halted_q <= 1'b1;
    end
  end

  assign bus.alu_result    = result;
  assign bus.store_data    = fwd_b;
  assign bus.flags         = flags_q;
  assign bus.flags_next    = update ? flags_fn : flags_q;
  assign bus.halted        = halted_q;
  assign bus.exmem_ctrl    = valid ? ctrl[3:0] : 4'h0;
  assign bus.exmem_dst_out = dst_id;
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expected values.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  ex_stage_if bus ();

  ex_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] C_V   = 7'h20;
  localparam logic [6:0] C_VR  = 7'h21;
  localparam logic [6:0] C_SRC = 7'h10;
  localparam logic [6:0] C_HLT = 7'h40;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [6:0] ctrl,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                       input logic [3:0] ra, input logic [3:0] rb);
    bus.idex_q = {5'b0, rb, ra, 4'd5, a, b, imm, {op, 12'h000}, ctrl};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.ex_stall       = 1'b0;
    bus.exmem_regwrite = 1'b0;
    bus.exmem_dst      = 4'd0;
    bus.exmem_result   = 16'h0;
    bus.memwb_regwrite = 1'b0;
    bus.memwb_dst      = 4'd0;
    bus.memwb_data     = 16'h0;
    drive(4'h0, 7'h0, 16'h0, 16'h0, 16'h0, 4'd1, 4'd2);
    tick();
    tick();
    check("rst_flags", 16'(bus.flags), 16'h0);
    check("rst_halted", 16'(bus.halted), 16'h0);
    rst = 1'b0;

    drive(4'h0, C_VR, 16'h0003, 16'h0004, 16'h0, 4'd1, 4'd2);
    check("add_res", bus.alu_result, 16'h0007);
    check("add_fnext", 16'(bus.flags_next), 16'h0);
    check("add_ctrl", 16'(bus.exmem_ctrl), 16'h1);
    check("add_dst", 16'(bus.exmem_dst_out), 16'h5);
    tick();
    check("add_flags", 16'(bus.flags), 16'h0);

    drive(4'h0, C_V, 16'h7FF0, 16'h0020, 16'h0, 4'd1, 4'd2);
    check("addsat_res", bus.alu_result, 16'h7FFF);
    tick();
    check("addsat_flags", 16'(bus.flags), 16'h2);
    drive(4'h1, C_V, 16'h8000, 16'h0001, 16'h0, 4'd1, 4'd2);
    check("subsat_res", bus.alu_result, 16'h8000);
    tick();
    check("subsat_flags", 16'(bus.flags), 16'h3);

    // Forwarding, as bubbles so flags stay at 011.
    bus.exmem_regwrite = 1'b1; bus.exmem_dst = 4'd3; bus.exmem_result = 16'h1111;
    bus.memwb_regwrite = 1'b1; bus.memwb_dst = 4'd3; bus.memwb_data   = 16'h2222;
    drive(4'h8, C_SRC | 7'h01, 16'h0005, 16'h0006, 16'h0000, 4'd3, 4'd3);
    check("fwd_exmem_a", bus.alu_result, 16'h1111);
    check("fwd_exmem_st", bus.store_data, 16'h1111);
    check("bubble_ctrl", 16'(bus.exmem_ctrl), 16'h0);
    bus.exmem_regwrite = 1'b0;
    #1;
    check("fwd_memwb_a", bus.alu_result, 16'h2222);
    check("fwd_memwb_st", bus.store_data, 16'h2222);
    bus.memwb_regwrite = 1'b0;
    #1;
    check("fwd_none_a", bus.alu_result, 16'h0005);
    check("fwd_none_st", bus.store_data, 16'h0006);
    tick();
    check("bubble_flags", 16'(bus.flags), 16'h3);

    drive(4'h2, C_V, 16'h00FF, 16'h00FF, 16'h0, 4'd1, 4'd2);
    check("xor_res", bus.alu_result, 16'h0000);
    check("xor_fnext", 16'(bus.flags_next), 16'h7);
    tick();
    check("xor_flags", 16'(bus.flags), 16'h7);
    drive(4'h8, C_V | C_SRC, 16'h0001, 16'h0009, 16'h0002, 4'd1, 4'd2);
    check("lw_res", bus.alu_result, 16'h0003);
    tick();
    check("lw_flags", 16'(bus.flags), 16'h7);
    drive(4'h0, 7'h00, 16'h0001, 16'h0001, 16'h0, 4'd1, 4'd2);
    check("bub_fnext", 16'(bus.flags_next), 16'h7);
    tick();
    check("bub_flags", 16'(bus.flags), 16'h7);
    bus.ex_stall = 1'b1;
    drive(4'h0, C_V, 16'h0001, 16'h0001, 16'h0, 4'd1, 4'd2);
    check("stall_res", bus.alu_result, 16'h0002);
    check("stall_fnext", 16'(bus.flags_next), 16'h7);
    tick();
    check("stall_flags", 16'(bus.flags), 16'h7);
    bus.ex_stall = 1'b0;

    // Combinational ALU vectors as bubbles.
    drive(4'h7, C_SRC, 16'h7777, 16'h1111, 16'h0000, 4'd1, 4'd2);
    check("paddsb_pos", bus.alu_result, 16'h7777);
    drive(4'h7, 7'h00, 16'h8888, 16'hFFFF, 16'h0, 4'd1, 4'd2);
    check("paddsb_neg", bus.alu_result, 16'h8888);
    drive(4'h7, 7'h00, 16'h1234, 16'h1111, 16'h0, 4'd1, 4'd2);
    check("paddsb_mix", bus.alu_result, 16'h2345);
    drive(4'h3, 7'h00, 16'h7F7F, 16'h0101, 16'h0, 4'd1, 4'd2);
    check("red_pos", bus.alu_result, 16'h0100);
    drive(4'h3, 7'h00, 16'hFFFF, 16'hFFFF, 16'h0, 4'd1, 4'd2);
    check("red_neg", bus.alu_result, 16'hFFFC);
    drive(4'h4, 7'h00, 16'h0001, 16'h0, 16'h0004, 4'd1, 4'd2);
    check("sll", bus.alu_result, 16'h0010);
    drive(4'h5, 7'h00, 16'h8000, 16'h0, 16'h000F, 4'd1, 4'd2);
    check("sra", bus.alu_result, 16'hFFFF);
    drive(4'h6, 7'h00, 16'h0001, 16'h0, 16'h0001, 4'd1, 4'd2);
    check("ror", bus.alu_result, 16'h8000);
    drive(4'hA, C_SRC, 16'h1234, 16'h0, 16'h00AB, 4'd1, 4'd2);
    check("llb", bus.alu_result, 16'h12AB);
    drive(4'hB, C_SRC, 16'h1234, 16'h0, 16'h00AB, 4'd1, 4'd2);
    check("lhb", bus.alu_result, 16'hAB34);
    drive(4'hC, C_SRC, 16'h1234, 16'h0, 16'h0042, 4'd1, 4'd2);
    check("pcs", bus.alu_result, 16'h0042);
    drive(4'h1, 7'h00, 16'h0005, 16'h0007, 16'h0, 4'd1, 4'd2);
    check("sub_wrap", bus.alu_result, 16'hFFFE);
    drive(4'h9, C_SRC, 16'h7FFF, 16'h0, 16'h0001, 4'd1, 4'd2);
    check("sw_nosat", bus.alu_result, 16'h8000);

    bus.ex_stall = 1'b1;
    drive(4'h0, C_V | C_HLT, 16'h0, 16'h0, 16'h0, 4'd1, 4'd2);
    tick();
    check("halt_stalled", 16'(bus.halted), 16'h0);
    bus.ex_stall = 1'b0;
    tick();
    check("halt_set", 16'(bus.halted), 16'h1);
    drive(4'h0, C_V, 16'h0001, 16'h0001, 16'h0, 4'd1, 4'd2);
    tick();
    check("halt_held", 16'(bus.halted), 16'h1);
    check("post_halt_flags", 16'(bus.flags), 16'h0);

    rst = 1'b1;
    drive(4'h0, C_V | C_HLT, 16'h7FF0, 16'h0020, 16'h0, 4'd1, 4'd2);
    tick();
    check("rst_pri_halted", 16'(bus.halted), 16'h0);
    check("rst_pri_flags", 16'(bus.flags), 16'h0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
